// File: rtl/dac_spi_master.sv
// SPI master for a dual-channel serial DAC: one 24-bit frame per accepted word.
// Mode 0 (SCK idles low), MSB first, one-deep input holding register.
module dac_spi_master #(
    parameter int         CLK_DIV    = 4,
    parameter int         CS_GAP     = 4,
    parameter logic [3:0] CTRL_UPPER = 4'h0,
    parameter bit         INVERT_MSB = 1'b0
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  IN_CHAN,
    input  logic [15:0] IN_DATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        CS_,
    output logic        SCK,
    output logic        SDO
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state, state_nx;
    logic [DW-1:0] div_cnt, div_nx;
    logic [GW-1:0] gap_cnt, gap_nx;
    logic [4:0]    bit_cnt, bit_nx;
    logic [23:0]   shreg, shreg_nx;
    logic [23:0]   hold_word;
    logic          hold_full;
    logic          cs_q, cs_nx;
    logic          sck_q, sck_nx;
    logic          sdo_q, sdo_nx;
    logic          done_q, done_nx;
    logic          load;
    logic          accept;
    logic          div_end;
    logic          gap_end;
    logic [15:0]   data_x;

    assign data_x   = INVERT_MSB ? {~IN_DATA[15], IN_DATA[14:0]} : IN_DATA;
    assign accept   = IN_VALID & ~hold_full;
    assign div_end  = (div_cnt == DW'(CLK_DIV - 1));
    assign gap_end  = (gap_cnt == GW'(CS_GAP - 1));

    assign IN_READY = ~hold_full;
    assign BUSY     = (state != IDLE);
    assign DONE     = done_q;
    assign CS_      = cs_q;
    assign SCK      = sck_q;
    assign SDO      = sdo_q;

    // Accept and load never coincide: accept needs the register empty.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_full <= 1'b0;
            hold_word <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_word <= {CTRL_UPPER, IN_CHAN, data_x};
        end else if (load) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= IDLE;
            div_cnt <= '0;
            gap_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nx;
            div_cnt <= div_nx;
            gap_cnt <= gap_nx;
            bit_cnt <= bit_nx;
            shreg   <= shreg_nx;
            cs_q    <= cs_nx;
            sck_q   <= sck_nx;
            sdo_q   <= sdo_nx;
            done_q  <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        gap_nx   = gap_cnt;
        bit_nx   = bit_cnt;
        shreg_nx = shreg;
        cs_nx    = cs_q;
        sck_nx   = sck_q;
        sdo_nx   = sdo_q;
        done_nx  = 1'b0;
        load     = 1'b0;

        unique case (state)
            IDLE: begin
                sck_nx = 1'b0;
                cs_nx  = 1'b1;
                if (hold_full) begin
                    load = 1'b1;
                end
            end
            SETUP: begin
                if (div_end) begin
                    div_nx   = '0;
                    sck_nx   = 1'b1;
                    bit_nx   = 5'd23;
                    state_nx = SHIFT;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_nx = div_cnt + DW'(1);
                end else begin
                    div_nx = '0;
                    // SDO only moves on the falling edge of SCK.
                    if (sck_q) begin
                        sck_nx = 1'b0;
                        sdo_nx = (bit_cnt == 5'd0) ? 1'b0
                                                   : shreg[bit_cnt - 5'd1];
                    end else if (bit_cnt == 5'd0) begin
                        state_nx = HOLD;
                    end else begin
                        sck_nx = 1'b1;
                        bit_nx = bit_cnt - 5'd1;
                    end
                end
            end
            HOLD: begin
                if (div_end) begin
                    div_nx   = '0;
                    gap_nx   = '0;
                    cs_nx    = 1'b1;
                    done_nx  = 1'b1;
                    state_nx = GAP;
                end else begin
                    div_nx = div_cnt + DW'(1);
                end
            end
            GAP: begin
                if (gap_end) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    gap_nx = gap_cnt + GW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (load) begin
            shreg_nx = hold_word;
            cs_nx    = 1'b0;
            sck_nx   = 1'b0;
            sdo_nx   = hold_word[23];
            div_nx   = '0;
            state_nx = SETUP;
        end
    end

endmodule

// File: tb/tb_dac_spi_master.sv
// Directed bench for dac_spi_master with a pin-level DAC model.
// u0 uses default parameters; u1 runs CLK_DIV=1, INVERT_MSB=1.
module tb_dac_spi_master;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_ready;
    logic [1:0]  busy;
    logic [1:0]  done;
    logic [1:0]  cs_n;
    logic [1:0]  sck;
    logic [1:0]  sdo;
    logic [3:0]  in_chan [2];
    logic [15:0] in_data [2];

    always #5 clk = ~clk;

    dac_spi_master u0 (
        .CLK(clk), .RESET(rst),
        .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]),
        .IN_CHAN(in_chan[0]), .IN_DATA(in_data[0]),
        .BUSY(busy[0]), .DONE(done[0]),
        .CS_(cs_n[0]), .SCK(sck[0]), .SDO(sdo[0])
    );

    dac_spi_master #(.CLK_DIV(1), .INVERT_MSB(1'b1)) u1 (
        .CLK(clk), .RESET(rst),
        .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]),
        .IN_CHAN(in_chan[1]), .IN_DATA(in_data[1]),
        .BUSY(busy[1]), .DONE(done[1]),
        .CS_(cs_n[1]), .SCK(sck[1]), .SDO(sdo[1])
    );

    // DAC model: samples on SCK rise, keeps a frame only if 24 bits seen.
    int          rises [2];
    int          done_n [2];
    int          frame_cnt [2];
    int          nbits [2];
    int          low_cnt [2];
    int          last_low [2];
    int          hi_cnt [2];
    int          last_gap [2];
    int          per_cnt [2];
    int          last_per [2];
    int          glitch [2];
    logic [23:0] sh [2];
    logic        hi_val [2];
    logic        sck_prev [2] = '{1'b0, 1'b0};
    logic        cs_prev [2] = '{1'b1, 1'b1};
    logic [23:0] frames [2][64];

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            sck_prev[i] <= sck[i];
            cs_prev[i]  <= cs_n[i];
            per_cnt[i]  <= per_cnt[i] + 1;
            if (!cs_n[i] && sck[i] && !sck_prev[i]) begin
                sh[i]       <= {sh[i][22:0], sdo[i]};
                nbits[i]    <= nbits[i] + 1;
                rises[i]    <= rises[i] + 1;
                hi_val[i]   <= sdo[i];
                last_per[i] <= per_cnt[i];
                per_cnt[i]  <= 1;
            end else if (sck[i] && sck_prev[i] && sdo[i] !== hi_val[i]) begin
                glitch[i] <= glitch[i] + 1;
            end
            if (done[i]) done_n[i] <= done_n[i] + 1;
            if (!cs_n[i]) low_cnt[i] <= low_cnt[i] + 1;
            else          hi_cnt[i]  <= hi_cnt[i] + 1;
            if (cs_n[i] && !cs_prev[i]) begin
                if (nbits[i] == 24) begin
                    frames[i][frame_cnt[i] % 64] <= sh[i];
                    frame_cnt[i] <= frame_cnt[i] + 1;
                end
                last_low[i] <= low_cnt[i];
                low_cnt[i]  <= 0;
                nbits[i]    <= 0;
                hi_cnt[i]   <= 1;
            end
            if (!cs_n[i] && cs_prev[i]) begin
                last_gap[i] <= hi_cnt[i];
                hi_cnt[i]   <= 0;
                low_cnt[i]  <= 1;
                nbits[i]    <= 0;
            end
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ch_a;
    logic [15:0] ch_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic send(input int d, input logic [3:0] c,
                        input logic [15:0] v, output int waits);
        waits       = 0;
        in_valid[d] = 1'b1;
        in_chan[d]  = c;
        in_data[d]  = v;
        while (!in_ready[d] && waits < 2000) begin
            @(negedge clk);
            waits++;
        end
        @(negedge clk);
        chk("send_accept", 32'(waits < 2000), 32'd1);
    endtask

    task automatic wait_frames(input int d, input int target, input string tag);
        int n;
        n = 0;
        while (frame_cnt[d] < target && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        chk(tag, 32'(frame_cnt[d]), 32'(target));
    endtask

    task automatic decode(input logic [23:0] f);
        if (f[19:16] == 4'd0) ch_a = f[15:0];
        else if (f[19:16] == 4'd1) ch_b = f[15:0];
    endtask

    initial begin
        int w, w3, fb, rb, db, n;
        rst      = 1'b1;
        in_valid = 2'b00;
        in_chan  = '{4'd0, 4'd0};
        in_data  = '{16'd0, 16'd0};
        ch_a     = 16'hxxxx;
        ch_b     = 16'hxxxx;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("rst_cs", 32'(cs_n[0]), 32'd1);
        chk("rst_sck", 32'(sck[0]), 32'd0);
        chk("rst_sdo", 32'(sdo[0]), 32'd0);
        chk("rst_busy", 32'(busy[0]), 32'd0);
        chk("rst_done", 32'(done[0]), 32'd0);
        chk("rst_ready", 32'(in_ready[0]), 32'd1);
        @(negedge clk);

        // 1: mid-scale code on channel A
        fb = frame_cnt[0]; rb = rises[0]; db = done_n[0];
        send(0, 4'd0, 16'h8000, w);
        in_valid[0] = 1'b0;
        chk("t1_cs_before", 32'(cs_n[0]), 32'd1);
        @(negedge clk);
        chk("t1_cs_fall", 32'(cs_n[0]), 32'd0);
        chk("t1_busy", 32'(busy[0]), 32'd1);
        wait_frames(0, fb + 1, "t1_frames");
        decode(frames[0][fb % 64]);
        chk("t1_ctrl", 32'(frames[0][fb % 64][23:16]), 32'h00);
        chk("t1_ch_a", 32'(ch_a), 32'h8000);
        chk("t1_display", 32'({~ch_a[15], ch_a[14:0]}), 32'h0000);
        chk("t1_cs_low", 32'(last_low[0]), 32'd200);
        chk("t1_rises", 32'(rises[0] - rb), 32'd24);
        chk("t1_done", 32'(done_n[0] - db), 32'd1);
        chk("t1_sck_per", 32'(last_per[0]), 32'd8);

        // 2: channel B
        fb = frame_cnt[0];
        send(0, 4'd1, 16'h1234, w);
        in_valid[0] = 1'b0;
        wait_frames(0, fb + 1, "t2_frames");
        decode(frames[0][fb % 64]);
        chk("t2_ctrl", 32'(frames[0][fb % 64][23:16]), 32'h01);
        chk("t2_ch_b", 32'(ch_b), 32'h1234);
        chk("t2_ch_a", 32'(ch_a), 32'h8000);
        chk("t2_sdo_stable", 32'(glitch[0]), 32'd0);

        // 3: back-to-back words
        fb = frame_cnt[0];
        send(0, 4'd0, 16'hAAAA, w);
        send(0, 4'd1, 16'h5555, w);
        in_valid[0] = 1'b0;
        chk("t3_acc_in_frame", 32'(cs_n[0]), 32'd0);
        wait_frames(0, fb + 2, "t3_frames");
        decode(frames[0][fb % 64]);
        decode(frames[0][(fb + 1) % 64]);
        chk("t3_gap", 32'(last_gap[0]), 32'd4);
        chk("t3_ch_a", 32'(ch_a), 32'hAAAA);
        chk("t3_ch_b", 32'(ch_b), 32'h5555);

        // 4: three words with IN_VALID held
        fb = frame_cnt[0];
        send(0, 4'd0, 16'h1111, w);
        send(0, 4'd1, 16'h2222, w);
        send(0, 4'd0, 16'h3333, w3);
        in_valid[0] = 1'b0;
        chk("t4_ready_low", 32'(w3 > 100), 32'd1);
        wait_frames(0, fb + 3, "t4_frames");
        chk("t4_f0", 32'(frames[0][fb % 64]), 32'h001111);
        chk("t4_f1", 32'(frames[0][(fb + 1) % 64]), 32'h012222);
        chk("t4_f2", 32'(frames[0][(fb + 2) % 64]), 32'h003333);
        repeat (300) @(negedge clk);
        chk("t4_no_dup", 32'(frame_cnt[0] - fb), 32'd3);

        // 5: reset after the 10th SCK rise, with a word waiting
        fb = frame_cnt[0]; rb = rises[0];
        send(0, 4'd1, 16'hBEEF, w);
        send(0, 4'd0, 16'h7777, w);
        in_valid[0] = 1'b0;
        n = 0;
        while (rises[0] < rb + 10 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("t5_rise10", 32'(rises[0] >= rb + 10), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_cs", 32'(cs_n[0]), 32'd1);
        chk("t5_sck", 32'(sck[0]), 32'd0);
        chk("t5_sdo", 32'(sdo[0]), 32'd0);
        chk("t5_ready", 32'(in_ready[0]), 32'd1);
        chk("t5_done", 32'(done[0]), 32'd0);
        chk("t5_busy", 32'(busy[0]), 32'd0);
        repeat (300) @(negedge clk);
        chk("t5_discard", 32'(frame_cnt[0] - fb), 32'd0);
        send(0, 4'd0, 16'h0F0F, w);
        in_valid[0] = 1'b0;
        wait_frames(0, fb + 1, "t5_frames");
        decode(frames[0][fb % 64]);
        chk("t5_word", 32'(frames[0][fb % 64]), 32'h000F0F);
        chk("t5_ch_a", 32'(ch_a), 32'h0F0F);

        // 6: fast divider with MSB inversion
        fb = frame_cnt[1]; rb = rises[1];
        send(1, 4'd0, 16'h0000, w);
        in_valid[1] = 1'b0;
        wait_frames(1, fb + 1, "t6_frames");
        chk("t6_word", 32'(frames[1][fb % 64]), 32'h008000);
        chk("t6_cs_low", 32'(last_low[1]), 32'd50);
        chk("t6_rises", 32'(rises[1] - rb), 32'd24);
        chk("t6_sck_per", 32'(last_per[1]), 32'd2);
        chk("t6_sdo_stable", 32'(glitch[1]), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
